// File: rtl/mips_prog_loader.sv
// Streams a program into instruction memory, then releases the core from base_addr.
// Define LOADER_CHECKSUM_EN to require a trailing check word equal to the running sum.
module mips_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = S_CHECK;
`else
  localparam state_t AFTER_LOAD = S_RUN;
`endif

  // Largest legal program fills the whole memory exactly.
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [DATA_W-1:0] sum;
  logic              accept_start;
  logic              load_beat;

  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_next   = state;
    s_ready      = 1'b0;
    accept_start = 1'b0;
    load_beat    = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          accept_start = 1'b1;
          if (word_count > MAX_COUNT)
            state_next = S_ERROR;
          else if (word_count == '0)
            state_next = AFTER_LOAD;
          else
            state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load_beat = 1'b1;
          if (idx_inc == count_q)
            state_next = AFTER_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // The check word is consumed here and never reaches memory.
      S_CHECK: begin
        s_ready = 1'b1;
        if (s_valid)
          state_next = (s_data == sum) ? S_RUN : S_ERROR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      base_q    <= '0;
      count_q   <= '0;
      idx       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= load_beat;
      if (accept_start) begin
        base_q  <= base_addr;
        count_q <= word_count;
        idx     <= '0;
        sum     <= '0;
      end
      // Address arithmetic wraps naturally at the top of memory.
      if (load_beat) begin
        idx       <= idx_inc;
        sum       <= sum + s_data;
        mem_addr  <= base_q + idx[ADDR_W-1:0];
        mem_wdata <= s_data;
      end
    end
  end

  assign core_run = (state == S_RUN);
  assign done     = (state == S_RUN);
  assign error    = (state == S_ERROR);
  assign busy     = (state != S_IDLE) && (state != S_RUN) && (state != S_ERROR);
  assign checksum = sum;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: a transaction-level model predicts every
// memory write (address, data, cycle), the running checksum and the final status.
`timescale 1ns/1ps
module tb_mips_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk1 = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_run;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t gotQ[$];
  wr_t expQ[$];

  mips_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_run  (core_run),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  always #5 clk1 = ~clk1;

  // Capture every memory write shortly after the edge that produced it.
  always @(posedge clk1) begin
    cyc++;
    #1;
    if (mem_we)
      gotQ.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_ctrl"}, {s_ready, mem_we, core_run, busy, done, error}, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wr_count"}, gotQ.size(), expQ.size());
    foreach (expQ[i]) begin
      if (i < gotQ.size()) begin
        checkOutput({tag, "_wr_addr"}, gotQ[i].addr, expQ[i].addr);
        checkOutput({tag, "_wr_data"}, gotQ[i].data, expQ[i].data);
        checkOutput({tag, "_wr_cycle"}, gotQ[i].cyc, expQ[i].cyc);
      end
    end
  endtask

  function automatic logic [ADDR_W-1:0] wrapAddr(input logic [ADDR_W-1:0] base, input int offset);
    return ADDR_W'((int'(base) + offset) % DEPTH);
  endfunction

  // gapMode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int count, input int gapMode,
                               input bit badCheck, input bit pokeStart, input bit seqData);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] word;
    int                beats;
    int                sent;
    int                iter;
    bit                v;
    bit                expRun;
    sum   = '0;
    beats = count + (CHK_EN ? 1 : 0);
    gotQ.delete();
    expQ.delete();
    @(negedge clk1);
    start      = 1'b1;
    base_addr  = base;
    word_count = count[ADDR_W:0];
    @(negedge clk1);
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = (ADDR_W+1)'($urandom);
    if (beats > 0) begin
      checkOutput("restart_status", {core_run, done, error}, 0);
      checkOutput("restart_checksum", checksum, 0);
    end
    sent = 0;
    iter = 0;
    while (sent < beats && iter < 8 * beats + 20) begin
      checkOutput("load_s_ready", s_ready, 1);
      checkOutput("load_busy", busy, 1);
      checkOutput("load_checksum", checksum, sum);
      start = pokeStart && (iter == 1);
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (iter % 2) == 0;
        default: v = ($urandom % 3) != 0;
      endcase
      if (v) begin
        if (sent < count) begin
          word = seqData ? DATA_W'(sent + 1) : $urandom;
          expQ.push_back('{addr: wrapAddr(base, sent), data: word, cyc: cyc + 1});
          sum += word;
        end else begin
          word = badCheck ? sum + 1'b1 : sum;
        end
        sent++;
      end else begin
        word = $urandom;
      end
      s_valid = v;
      s_data  = word;
      iter++;
      @(negedge clk1);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    checkOutput("beat_budget", sent, beats);
    expRun = !(CHK_EN && badCheck);
    checkOutput("end_core_run", core_run, expRun);
    checkOutput("end_done", done, expRun);
    checkOutput("end_error", error, !expRun);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_s_ready", s_ready, 0);
    checkOutput("end_checksum", checksum, sum);
    repeat (3) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      @(negedge clk1);
      checkOutput("hold_s_ready", s_ready, 0);
      checkOutput("hold_status", {core_run, done, error}, {expRun, expRun, !expRun});
      checkOutput("hold_checksum", checksum, sum);
    end
    s_valid = 1'b0;
    checkWrites("load");
  endtask

  task automatic startError(input int count);
    gotQ.delete();
    @(negedge clk1);
    start      = 1'b1;
    base_addr  = ADDR_W'($urandom);
    word_count = count[ADDR_W:0];
    @(negedge clk1);
    start = 1'b0;
    checkOutput("err_status", {core_run, done, error, busy}, 4'b0010);
    checkOutput("err_checksum", checksum, 0);
    repeat (4) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      checkOutput("err_s_ready", s_ready, 0);
      @(negedge clk1);
    end
    s_valid = 1'b0;
    checkOutput("err_writes", gotQ.size(), 0);
  endtask

  task automatic resetMidLoad(input logic [ADDR_W-1:0] base);
    logic [DATA_W-1:0] word;
    gotQ.delete();
    expQ.delete();
    @(negedge clk1);
    start      = 1'b1;
    base_addr  = base;
    word_count = 11'd5;
    @(negedge clk1);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word = $urandom;
      expQ.push_back('{addr: wrapAddr(base, i), data: word, cyc: cyc + 1});
      s_valid = 1'b1;
      s_data  = word;
      @(negedge clk1);
    end
    rst     = 1'b1;
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = $urandom;
    @(negedge clk1);
    checkZero("rst_mid");
    rst     = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk1);
    checkZero("rst_idle");
    checkWrites("rst_abort");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    base_addr  = '0;
    word_count = '0;
    repeat (3) @(negedge clk1);
    checkZero("reset");
    rst = 1'b0;
    @(negedge clk1);
    checkZero("idle");

    applyStimulus(10'd0, 3, 0, 1'b0, 1'b0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(10'd0, 3, 0, 1'b1, 1'b0, 1'b1);
`endif
    applyStimulus(10'd1022, 4, 1, 1'b0, 1'b0, 1'b0);
    startError(1025);
    startError(2047);
    applyStimulus(10'd77, 0, 0, 1'b0, 1'b0, 1'b0);
    resetMidLoad(10'd37);
    applyStimulus(10'd600, 2, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(10'd100, 6, 2, 1'b0, 1'b1, 1'b0);
    applyStimulus(10'd5, 4, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 15; n++)
      applyStimulus(ADDR_W'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                    1'($urandom), 1'($urandom), 1'b0);

    applyStimulus(ADDR_W'($urandom), DEPTH, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the word-address width of the instruction memory (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 SHALL have port clk1  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a program load.
REQ-006 SHALL have port base_addr  input  ADDR_W  first memory word address, sampled when start is accepted.
REQ-007 SHALL have port word_count  input  ADDR_W+1  number of program words, sampled when start is accepted.
REQ-008 SHALL have ports s_valid (input, 1), s_data (input, DATA_W) and s_ready (output, 1), forming the upstream word stream; a beat transfers when s_valid and s_ready are both 1.
REQ-009 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), forming the instruction-memory write port.
REQ-010 SHALL have port core_run  output  1  when 1, the downstream pipeline may fetch from PC=base_addr; when 0, it is held.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), error (output, 1) and checksum (output, DATA_W), which report status.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, CHECK, RUN and ERROR.
REQ-013 IDLE: s_ready=0, core_run=0. On start, SHALL latch base_addr and word_count, clear the word index and running sum, and go to LOAD in the next cycle.
REQ-014 A start with word_count > 2^ADDR_W SHALL go to ERROR instead of LOAD.
REQ-015 A start with word_count = 0 SHALL go directly to CHECK (macro defined) or RUN (macro undefined).
REQ-016 LOAD: s_ready SHALL be 1. Each accepted beat SHALL increment the index and add s_data to the running sum, wrapping modulo 2^DATA_W.
REQ-017 Each write SHALL be registered: in the cycle after the beat, mem_we=1, mem_addr=(base+index) mod 2^ADDR_W and mem_wdata=beat data. Address wrap from 1023 to 0 is legal.
REQ-018 mem_we SHALL be 0 in every cycle that does not follow an accepted LOAD beat. Throughput SHALL be one word per cycle, and s_valid gaps SHALL be tolerated.
REQ-019 On acceptance of beat word_count-1, the FSM SHALL leave LOAD (to CHECK or RUN) in the next cycle, and s_ready SHALL drop in that cycle.
REQ-020 RUN: core_run=1, done=1, busy=0, s_ready=0. RUN SHALL be held until rst or start.
REQ-021 ERROR: error=1, core_run=0, s_ready=0. ERROR SHALL be held until rst or start.
REQ-022 busy SHALL be 1 in LOAD and CHECK only.
REQ-023 start in RUN or ERROR SHALL restart the load. core_run, done and error SHALL clear in the next cycle.
REQ-024 start in LOAD or CHECK SHALL be ignored.
REQ-025 checksum SHALL present the running sum continuously. It SHALL be frozen outside LOAD.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear the index, sum, latched base and count.
REQ-027 Reset values SHALL be: s_ready, mem_we, core_run, busy, done, error = 0; mem_addr, mem_wdata, checksum = 0.
REQ-028 Reset asserted mid-LOAD SHALL abort the load without producing a write in the following cycle. Reset SHALL take priority over start and s_valid.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined:
- CHECK state exists with s_ready=1.
- One extra beat is accepted and compared to the running sum; match goes to RUN, mismatch goes to ERROR.
- The check word is never written to memory.
REQ-030 LOADER_CHECKSUM_EN undefined:
- CHECK state is absent.
- The last LOAD beat goes directly to RUN.
- The running sum and checksum output are still maintained.

Verification
REQ-031 rst, then start with base=0, count=3, words 0x00000001/0x00000002/0x00000003 back-to-back -> writes to addr 0/1/2 on consecutive cycles. With the macro, check word 0x00000006 -> core_run=1, done=1.
REQ-032 Same as REQ-031 with check word 0x00000007 (macro defined) -> error=1, core_run=0, no further writes.
REQ-033 base=1022, count=4 with s_valid toggling every other cycle -> writes to 1022, 1023, 0, 1. mem_we is 0 in gap cycles.
REQ-034 start with count=1025 -> ERROR on the next cycle, and no s_ready is ever asserted. start with count=0 -> CHECK (macro defined) or RUN (macro undefined).
REQ-035 rst pulsed after 2 of 5 beats -> IDLE next cycle, all outputs 0, no write from the aborted beat. A new start of 2 words -> addresses restart from the new base.
REQ-036 start pulsed in LOAD -> ignored. start pulsed in RUN -> core_run=0 the next cycle and a fresh load begins.
